// File: rtl/id_stage_pipe_if.sv
// -----------------------------------------------------------------------------
// id_stage_pipe_if
// Handshake channels around the decode stage.
//   IF -> ID : in_valid, in_ready, pc_in, instruction_in
//   ID -> EX : out_valid, out_ready and the registered decode bundle
//              (pc, instruction, val_Rn, val_Rm, src1, src2, dst,
//               signed_immediate, shifter_operand, imm, b, sr_update,
//               mem_read, mem_write, wb_en_out, ex_command)
// Modports:
//   master : the surrounding pipeline (drives IF side and out_ready)
//   slave  : the decode stage itself
// -----------------------------------------------------------------------------
interface id_stage_pipe_if #(
   parameter int WORD_WIDTH            = 32,
   parameter int REG_ADDR_W            = 4,
   parameter int SIGNED_IMM_WIDTH      = 24,
   parameter int SHIFTER_OPERAND_WIDTH = 12
);
   // IF -> ID
   logic                             in_valid;
   logic                             in_ready;
   logic [WORD_WIDTH-1:0]            pc_in;
   logic [WORD_WIDTH-1:0]            instruction_in;

   // ID -> EX
   logic                             out_valid;
   logic                             out_ready;
   logic [WORD_WIDTH-1:0]            pc;
   logic [WORD_WIDTH-1:0]            instruction;
   logic [WORD_WIDTH-1:0]            val_Rn;
   logic [WORD_WIDTH-1:0]            val_Rm;
   logic [REG_ADDR_W-1:0]            src1;
   logic [REG_ADDR_W-1:0]            src2;
   logic [REG_ADDR_W-1:0]            dst;
   logic [SIGNED_IMM_WIDTH-1:0]      signed_immediate;
   logic [SHIFTER_OPERAND_WIDTH-1:0] shifter_operand;
   logic                             imm;
   logic                             b;
   logic                             sr_update;
   logic                             mem_read;
   logic                             mem_write;
   logic                             wb_en_out;
   logic [3:0]                       ex_command;

   modport master (
      output in_valid, pc_in, instruction_in, out_ready,
      input  in_ready, out_valid, pc, instruction, val_Rn, val_Rm,
             src1, src2, dst, signed_immediate, shifter_operand,
             imm, b, sr_update, mem_read, mem_write, wb_en_out, ex_command
   );

   modport slave (
      input  in_valid, pc_in, instruction_in, out_ready,
      output in_ready, out_valid, pc, instruction, val_Rn, val_Rm,
             src1, src2, dst, signed_immediate, shifter_operand,
             imm, b, sr_update, mem_read, mem_write, wb_en_out, ex_command
   );
endinterface

// File: rtl/id_stage_pipe.sv
// -----------------------------------------------------------------------------
// id_stage_pipe
// Decode stage with register file, write-through bypass, RAW interlock and
// the ID/EX pipeline register.
// Ports:
//   clk             rising-edge clock
//   rst             asynchronous active-low reset
//   bus             IF->ID and ID->EX handshake channels (slave side)
//   status_register NZCV flags used for condition evaluation
//   flush           kills the held bundle and blocks the presented instruction
//   wb_en/addr/data register-file write port
//   ex_*/mem_*      in-flight writers used for hazard detection
//   hazard          combinational RAW-hazard indication
//   stall_count     saturating count of hazard-stall cycles
// -----------------------------------------------------------------------------
module id_stage_pipe #(
   parameter int WORD_WIDTH            = 32,
   parameter int REG_COUNT             = 16,
   parameter int REG_ADDR_W            = 4,
   parameter int SIGNED_IMM_WIDTH      = 24,
   parameter int SHIFTER_OPERAND_WIDTH = 12,
   parameter int STALL_CNT_W           = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   id_stage_pipe_if.slave         bus,
   input  logic [3:0]             status_register,
   input  logic                   flush,
   input  logic                   wb_en,
   input  logic [REG_ADDR_W-1:0]  wb_addr,
   input  logic [WORD_WIDTH-1:0]  wb_data,
   input  logic                   ex_wb_en,
   input  logic [REG_ADDR_W-1:0]  ex_dst,
   input  logic                   mem_wb_en,
   input  logic [REG_ADDR_W-1:0]  mem_dst,
   output logic                   hazard,
   output logic [STALL_CNT_W-1:0] stall_count
);

   typedef enum logic [3:0] {
      CMD_NOP = 4'h0,
      CMD_MOV = 4'h1,
      CMD_ADD = 4'h2,
      CMD_ADC = 4'h3,
      CMD_SUB = 4'h4,
      CMD_SBC = 4'h5,
      CMD_AND = 4'h6,
      CMD_ORR = 4'h7,
      CMD_EOR = 4'h8,
      CMD_MVN = 4'h9
   } alu_cmd_e;

   typedef enum logic [3:0] {
      OP_AND = 4'h0,
      OP_EOR = 4'h1,
      OP_SUB = 4'h2,
      OP_RSB = 4'h3,
      OP_ADD = 4'h4,
      OP_ADC = 4'h5,
      OP_SBC = 4'h6,
      OP_RSC = 4'h7,
      OP_TST = 4'h8,
      OP_TEQ = 4'h9,
      OP_CMP = 4'hA,
      OP_CMN = 4'hB,
      OP_ORR = 4'hC,
      OP_MOV = 4'hD,
      OP_BIC = 4'hE,
      OP_MVN = 4'hF
   } dp_op_e;

   typedef enum logic [1:0] {
      MODE_DP  = 2'b00,
      MODE_MEM = 2'b01,
      MODE_BR  = 2'b10,
      MODE_RSV = 2'b11
   } inst_mode_e;

   typedef enum logic [3:0] {
      C_EQ = 4'h0, C_NE = 4'h1, C_CS = 4'h2, C_CC = 4'h3,
      C_MI = 4'h4, C_PL = 4'h5, C_VS = 4'h6, C_VC = 4'h7,
      C_HI = 4'h8, C_LS = 4'h9, C_GE = 4'hA, C_LT = 4'hB,
      C_GT = 4'hC, C_LE = 4'hD, C_AL = 4'hE, C_NV = 4'hF
   } cond_e;

   typedef enum logic {
      S_EMPTY = 1'b0,
      S_FULL  = 1'b1
   } state_e;

   // ---------------------------------------------------------------- decode
   inst_mode_e mode;
   dp_op_e     opcode;
   cond_e      cond;
   logic       s_bit;

   alu_cmd_e dec_cmd;
   logic     dec_wb;
   logic     dec_mr;
   logic     dec_mw;
   logic     dec_b;
   logic     dec_s;
   logic     has_src1;
   logic     has_src2;
   logic     cond_pass;

   logic [REG_ADDR_W-1:0] src1_idx;
   logic [REG_ADDR_W-1:0] src2_idx;
   logic [REG_ADDR_W-1:0] dst_idx;

   assign mode   = inst_mode_e'(bus.instruction_in[27:26]);
   assign opcode = dp_op_e'(bus.instruction_in[24:21]);
   assign cond   = cond_e'(bus.instruction_in[31:28]);
   assign s_bit  = bus.instruction_in[20];

   always_comb begin
      dec_cmd  = CMD_NOP;
      dec_wb   = 1'b0;
      dec_mr   = 1'b0;
      dec_mw   = 1'b0;
      dec_b    = 1'b0;
      dec_s    = 1'b0;
      has_src1 = 1'b0;
      unique case (mode)
         MODE_DP: begin
            dec_s    = s_bit;
            has_src1 = 1'b1;
            case (opcode)
               OP_MOV: begin dec_cmd = CMD_MOV; dec_wb = 1'b1; has_src1 = 1'b0; end
               OP_MVN: begin dec_cmd = CMD_MVN; dec_wb = 1'b1; has_src1 = 1'b0; end
               OP_ADD: begin dec_cmd = CMD_ADD; dec_wb = 1'b1; end
               OP_ADC: begin dec_cmd = CMD_ADC; dec_wb = 1'b1; end
               OP_SUB: begin dec_cmd = CMD_SUB; dec_wb = 1'b1; end
               OP_SBC: begin dec_cmd = CMD_SBC; dec_wb = 1'b1; end
               OP_AND: begin dec_cmd = CMD_AND; dec_wb = 1'b1; end
               OP_ORR: begin dec_cmd = CMD_ORR; dec_wb = 1'b1; end
               OP_EOR: begin dec_cmd = CMD_EOR; dec_wb = 1'b1; end
               OP_CMP: dec_cmd = CMD_SUB;
               OP_TST: dec_cmd = CMD_AND;
               default: ;
            endcase
         end
         MODE_MEM: begin
            // LDR and STR both compute Rn + offset in EX
            dec_cmd  = CMD_ADD;
            has_src1 = 1'b1;
            if (s_bit) begin
               dec_mr = 1'b1;
               dec_wb = 1'b1;
            end else begin
               dec_mw = 1'b1;
            end
         end
         MODE_BR:  dec_b = 1'b1;
         MODE_RSV: ;
      endcase
   end

   // NZCV = status_register[3:0]; NV is treated as always for compatibility
   always_comb begin
      logic n, z, c, v;
      n = status_register[3];
      z = status_register[2];
      c = status_register[1];
      v = status_register[0];
      cond_pass = 1'b0;
      unique case (cond)
         C_EQ: cond_pass = z;
         C_NE: cond_pass = ~z;
         C_CS: cond_pass = c;
         C_CC: cond_pass = ~c;
         C_MI: cond_pass = n;
         C_PL: cond_pass = ~n;
         C_VS: cond_pass = v;
         C_VC: cond_pass = ~v;
         C_HI: cond_pass = c & ~z;
         C_LS: cond_pass = ~c | z;
         C_GE: cond_pass = (n == v);
         C_LT: cond_pass = (n != v);
         C_GT: cond_pass = ~z & (n == v);
         C_LE: cond_pass = z | (n != v);
         C_AL: cond_pass = 1'b1;
         C_NV: cond_pass = 1'b1;
      endcase
   end

   // Stores read the data register through the second read port
   assign src1_idx = bus.instruction_in[16 +: REG_ADDR_W];
   assign dst_idx  = bus.instruction_in[12 +: REG_ADDR_W];
   assign src2_idx = dec_mw ? bus.instruction_in[12 +: REG_ADDR_W]
                            : bus.instruction_in[0 +: REG_ADDR_W];
   assign has_src2 = ~bus.instruction_in[25] | dec_mw;

   // --------------------------------------------------------- register file
   logic [WORD_WIDTH-1:0] regs [REG_COUNT];
   logic [WORD_WIDTH-1:0] rn_val;
   logic [WORD_WIDTH-1:0] rm_val;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int unsigned i = 0; i < REG_COUNT; i++) begin
            regs[i] <= '0;
         end
      end else if (wb_en) begin
         regs[wb_addr] <= wb_data;
      end
   end

   always_comb begin
      rn_val = regs[src1_idx];
      rm_val = regs[src2_idx];
      if (wb_en && (wb_addr == src1_idx)) rn_val = wb_data;
      if (wb_en && (wb_addr == src2_idx)) rm_val = wb_data;
   end

   // ---------------------------------------------------------------- hazard
   logic src1_hit;
   logic src2_hit;

   assign src1_hit = (ex_wb_en  && (ex_dst  == src1_idx)) ||
                     (mem_wb_en && (mem_dst == src1_idx));
   assign src2_hit = (ex_wb_en  && (ex_dst  == src2_idx)) ||
                     (mem_wb_en && (mem_dst == src2_idx));
   assign hazard   = bus.in_valid & ((has_src1 & src1_hit) | (has_src2 & src2_hit));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_count <= '0;
      end else if (hazard && !flush && !(&stall_count)) begin
         stall_count <= stall_count + STALL_CNT_W'(1);
      end
   end

   // ------------------------------------------------------ handshake / FSM
   state_e state;
   state_e state_next;
   logic   out_valid;
   logic   in_ready;
   logic   load;

   assign out_valid = (state == S_FULL);
   assign in_ready  = ~flush & ~hazard & (~out_valid | bus.out_ready);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= S_EMPTY;
      else      state <= state_next;
   end

   always_comb begin
      state_next = state;
      load       = 1'b0;
      if (flush) begin
         state_next = S_EMPTY;
      end else if (bus.in_valid && in_ready) begin
         state_next = S_FULL;
         load       = 1'b1;
      end else if (out_valid && bus.out_ready) begin
         state_next = S_EMPTY;
      end
   end

   // ---------------------------------------------------------- ID/EX bundle
   logic [WORD_WIDTH-1:0] pc_q;
   logic [WORD_WIDTH-1:0] instruction_q;
   logic [WORD_WIDTH-1:0] val_rn_q;
   logic [WORD_WIDTH-1:0] val_rm_q;
   logic [REG_ADDR_W-1:0] src1_q;
   logic [REG_ADDR_W-1:0] src2_q;
   logic [REG_ADDR_W-1:0] dst_q;
   logic                  imm_q;
   logic                  b_q;
   logic                  sr_update_q;
   logic                  mem_read_q;
   logic                  mem_write_q;
   logic                  wb_en_q;
   alu_cmd_e              ex_command_q;

   // A failed condition still loads a bundle so the PC flows, but with
   // every side effect stripped
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc_q          <= '0;
         instruction_q <= '0;
         val_rn_q      <= '0;
         val_rm_q      <= '0;
         src1_q        <= '0;
         src2_q        <= '0;
         dst_q         <= '0;
         imm_q         <= 1'b0;
         b_q           <= 1'b0;
         sr_update_q   <= 1'b0;
         mem_read_q    <= 1'b0;
         mem_write_q   <= 1'b0;
         wb_en_q       <= 1'b0;
         ex_command_q  <= CMD_NOP;
      end else if (load) begin
         pc_q          <= bus.pc_in;
         instruction_q <= bus.instruction_in;
         val_rn_q      <= rn_val;
         val_rm_q      <= rm_val;
         src1_q        <= src1_idx;
         src2_q        <= src2_idx;
         dst_q         <= dst_idx;
         imm_q         <= bus.instruction_in[25];
         b_q           <= dec_b  & cond_pass;
         sr_update_q   <= dec_s  & cond_pass;
         mem_read_q    <= dec_mr & cond_pass;
         mem_write_q   <= dec_mw & cond_pass;
         wb_en_q       <= dec_wb & cond_pass;
         ex_command_q  <= cond_pass ? dec_cmd : CMD_NOP;
      end
   end

   assign bus.in_ready         = in_ready;
   assign bus.out_valid        = out_valid;
   assign bus.pc               = pc_q;
   assign bus.instruction      = instruction_q;
   assign bus.val_Rn           = val_rn_q;
   assign bus.val_Rm           = val_rm_q;
   assign bus.src1             = src1_q;
   assign bus.src2             = src2_q;
   assign bus.dst              = dst_q;
   assign bus.signed_immediate = instruction_q[SIGNED_IMM_WIDTH-1:0];
   assign bus.shifter_operand  = instruction_q[SHIFTER_OPERAND_WIDTH-1:0];
   assign bus.imm              = imm_q;
   assign bus.b                = b_q;
   assign bus.sr_update        = sr_update_q;
   assign bus.mem_read         = mem_read_q;
   assign bus.mem_write        = mem_write_q;
   assign bus.wb_en_out        = wb_en_q;
   assign bus.ex_command       = ex_command_q;

endmodule

// File: tb/tb_id_stage_pipe.sv
// -----------------------------------------------------------------------------
// tb_id_stage_pipe
// Directed plus random stimulus for id_stage_pipe. A cycle model decides
// acceptance and pushes the expected bundle; a monitor pops and compares it
// whenever EX consumes a bundle.
// -----------------------------------------------------------------------------
module tb_id_stage_pipe;
   localparam int W   = 32;
   localparam int AW  = 4;
   localparam int SCW = 4;
   localparam int STALL_MAX = (1 << SCW) - 1;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   id_stage_pipe_if #(
      .WORD_WIDTH(W), .REG_ADDR_W(AW),
      .SIGNED_IMM_WIDTH(24), .SHIFTER_OPERAND_WIDTH(12)
   ) bus ();

   logic [3:0]     status_register;
   logic           flush;
   logic           wb_en;
   logic [AW-1:0]  wb_addr;
   logic [W-1:0]   wb_data;
   logic           ex_wb_en;
   logic [AW-1:0]  ex_dst;
   logic           mem_wb_en;
   logic [AW-1:0]  mem_dst;
   logic           hazard;
   logic [SCW-1:0] stall_count;

   id_stage_pipe #(
      .WORD_WIDTH(W), .REG_COUNT(16), .REG_ADDR_W(AW),
      .SIGNED_IMM_WIDTH(24), .SHIFTER_OPERAND_WIDTH(12), .STALL_CNT_W(SCW)
   ) dut (
      .clk(clk), .rst(rst_n), .bus(bus),
      .status_register(status_register), .flush(flush),
      .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
      .ex_wb_en(ex_wb_en), .ex_dst(ex_dst),
      .mem_wb_en(mem_wb_en), .mem_dst(mem_dst),
      .hazard(hazard), .stall_count(stall_count)
   );

   typedef struct {
      logic [31:0] pc, ins, rn, rm;
      logic [3:0]  s1, s2, d, cmd;
      logic        imm, b, s, mr, mw, wb;
   } bundle_t;

   typedef struct {
      logic [3:0] cmd;
      logic       wb, mr, mw, b, s, rn_used;
   } ctl_t;

   bundle_t     exp_q[$];
   int unsigned vectors = 0;
   int unsigned miscompares = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%08h, want 0x%08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ------------------------------------------------------ reference model
   function automatic logic cond_holds(input logic [3:0] c, input logic [3:0] f);
      logic n, z, cy, v;
      n = f[3]; z = f[2]; cy = f[1]; v = f[0];
      case (c)
         4'd0:  return z;
         4'd1:  return !z;
         4'd2:  return cy;
         4'd3:  return !cy;
         4'd4:  return n;
         4'd5:  return !n;
         4'd6:  return v;
         4'd7:  return !v;
         4'd8:  return cy && !z;
         4'd9:  return !cy || z;
         4'd10: return n == v;
         4'd11: return n != v;
         4'd12: return !z && (n == v);
         4'd13: return z || (n != v);
         default: return 1'b1;
      endcase
   endfunction

   // Mnemonic table: MOV=1 ADD=2 ADC=3 SUB=4 SBC=5 AND=6 ORR=7 EOR=8 MVN=9
   function automatic ctl_t ref_ctl(input logic [31:0] ins);
      ctl_t c;
      c = '{cmd: 4'd0, wb: 1'b0, mr: 1'b0, mw: 1'b0, b: 1'b0, s: 1'b0, rn_used: 1'b0};
      if (ins[27:26] == 2'b00) begin
         c.s = ins[20];
         c.rn_used = 1'b1;
         case (ins[24:21])
            4'hD: begin c.cmd = 4'd1; c.wb = 1'b1; c.rn_used = 1'b0; end
            4'hF: begin c.cmd = 4'd9; c.wb = 1'b1; c.rn_used = 1'b0; end
            4'h4: begin c.cmd = 4'd2; c.wb = 1'b1; end
            4'h5: begin c.cmd = 4'd3; c.wb = 1'b1; end
            4'h2: begin c.cmd = 4'd4; c.wb = 1'b1; end
            4'h6: begin c.cmd = 4'd5; c.wb = 1'b1; end
            4'h0: begin c.cmd = 4'd6; c.wb = 1'b1; end
            4'hC: begin c.cmd = 4'd7; c.wb = 1'b1; end
            4'h1: begin c.cmd = 4'd8; c.wb = 1'b1; end
            4'hA: c.cmd = 4'd4;
            4'h8: c.cmd = 4'd6;
            default: ;
         endcase
      end else if (ins[27:26] == 2'b01) begin
         c.cmd = 4'd2;
         c.rn_used = 1'b1;
         if (ins[20]) begin c.mr = 1'b1; c.wb = 1'b1; end
         else         c.mw = 1'b1;
      end else if (ins[27:26] == 2'b10) begin
         c.b = 1'b1;
      end
      return c;
   endfunction

   logic [31:0] m_regs [16];
   logic        m_valid;
   int unsigned m_stall;

   function automatic logic [31:0] m_read(input logic [3:0] idx);
      if (wb_en && wb_addr == idx) return wb_data;
      return m_regs[idx];
   endfunction

   function automatic logic writer_hits(input logic [3:0] idx);
      return (ex_wb_en && ex_dst == idx) || (mem_wb_en && mem_dst == idx);
   endfunction

   ctl_t       mc;
   logic [3:0] ms1, ms2;
   logic       mhz, mrdy, macc, mpass;
   bundle_t    eb;

   always @(negedge clk) begin : ref_model
      if (!rst_n) begin
         m_valid = 1'b0;
         m_stall = 0;
         exp_q.delete();
         for (int i = 0; i < 16; i++) m_regs[i] = '0;
      end else begin
         mc   = ref_ctl(bus.instruction_in);
         ms1  = bus.instruction_in[19:16];
         ms2  = mc.mw ? bus.instruction_in[15:12] : bus.instruction_in[3:0];
         mhz  = bus.in_valid && ((mc.rn_used && writer_hits(ms1)) ||
                ((!bus.instruction_in[25] || mc.mw) && writer_hits(ms2)));
         mrdy = !flush && !mhz && (!m_valid || bus.out_ready);
         check("hazard",      32'(hazard),        32'(mhz));
         check("in_ready",    32'(bus.in_ready),  32'(mrdy));
         check("out_valid",   32'(bus.out_valid), 32'(m_valid));
         check("stall_count", 32'(stall_count),   m_stall);
         macc = bus.in_valid && mrdy;
         if (macc) begin
            mpass  = cond_holds(bus.instruction_in[31:28], status_register);
            eb.pc  = bus.pc_in;
            eb.ins = bus.instruction_in;
            eb.rn  = m_read(ms1);
            eb.rm  = m_read(ms2);
            eb.s1  = ms1;
            eb.s2  = ms2;
            eb.d   = bus.instruction_in[15:12];
            eb.imm = bus.instruction_in[25];
            eb.cmd = mpass ? mc.cmd : 4'd0;
            eb.b   = mpass && mc.b;
            eb.s   = mpass && mc.s;
            eb.mr  = mpass && mc.mr;
            eb.mw  = mpass && mc.mw;
            eb.wb  = mpass && mc.wb;
            exp_q.push_back(eb);
         end
         if (flush) begin
            if (m_valid) void'(exp_q.pop_front());
            m_valid = 1'b0;
         end else if (macc) begin
            m_valid = 1'b1;
         end else if (m_valid && bus.out_ready) begin
            m_valid = 1'b0;
         end
         if (mhz && !flush && m_stall < STALL_MAX) m_stall++;
         if (wb_en) m_regs[wb_addr] = wb_data;
      end
   end

   // -------------------------------------------------------------- monitor
   bundle_t got;
   always @(negedge clk) begin : monitor
      if (rst_n && bus.out_valid && bus.out_ready) begin
         if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_bundle: got pc 0x%08h, want no bundle", bus.pc);
         end else begin
            got = exp_q.pop_front();
            check("pc",               bus.pc,                 got.pc);
            check("instruction",      bus.instruction,        got.ins);
            check("val_Rn",           bus.val_Rn,             got.rn);
            check("val_Rm",           bus.val_Rm,             got.rm);
            check("src1",             32'(bus.src1),          32'(got.s1));
            check("src2",             32'(bus.src2),          32'(got.s2));
            check("dst",              32'(bus.dst),           32'(got.d));
            check("signed_immediate", 32'(bus.signed_immediate), 32'(got.ins[23:0]));
            check("shifter_operand",  32'(bus.shifter_operand),  32'(got.ins[11:0]));
            check("imm",              32'(bus.imm),           32'(got.imm));
            check("b",                32'(bus.b),             32'(got.b));
            check("sr_update",        32'(bus.sr_update),     32'(got.s));
            check("mem_read",         32'(bus.mem_read),      32'(got.mr));
            check("mem_write",        32'(bus.mem_write),     32'(got.mw));
            check("wb_en_out",        32'(bus.wb_en_out),     32'(got.wb));
            check("ex_command",       32'(bus.ex_command),    32'(got.cmd));
         end
      end
   end

   // ------------------------------------------------------------- stimulus
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.in_valid = 1'b0;
      bus.pc_in = '0;
      bus.instruction_in = '0;
      bus.out_ready = 1'b0;
      status_register = 4'h0;
      flush = 1'b0;
      wb_en = 1'b0;
      wb_addr = '0;
      wb_data = '0;
      ex_wb_en = 1'b0;
      ex_dst = '0;
      mem_wb_en = 1'b0;
      mem_dst = '0;
   endtask

   task automatic present(input logic [31:0] ins, input logic [31:0] pcv, input logic rdy);
      bus.in_valid = 1'b1;
      bus.instruction_in = ins;
      bus.pc_in = pcv;
      bus.out_ready = rdy;
   endtask

   task automatic reset_zero_checks();
      check("rst_out_valid",   32'(bus.out_valid),  32'd0);
      check("rst_pc",          bus.pc,              32'd0);
      check("rst_instruction", bus.instruction,     32'd0);
      check("rst_val_Rn",      bus.val_Rn,          32'd0);
      check("rst_val_Rm",      bus.val_Rm,          32'd0);
      check("rst_dst",         32'(bus.dst),        32'd0);
      check("rst_wb_en_out",   32'(bus.wb_en_out),  32'd0);
      check("rst_ex_command",  32'(bus.ex_command), 32'd0);
      check("rst_stall_count", 32'(stall_count),    32'd0);
   endtask

   function automatic logic [31:0] rand_instr();
      logic [31:0] r;
      logic [3:0]  cnd;
      logic [3:0]  op;
      int unsigned k;
      int unsigned sel;
      r   = $urandom;
      k   = $urandom_range(0, 9);
      sel = $urandom_range(0, 10);
      cnd = ($urandom_range(0, 1) == 1) ? 4'hE : 4'($urandom_range(0, 15));
      case (sel)
         0: op = 4'hD;  1: op = 4'hF;  2: op = 4'h4;  3: op = 4'h5;
         4: op = 4'h2;  5: op = 4'h6;  6: op = 4'h0;  7: op = 4'hC;
         8: op = 4'h1;  9: op = 4'hA;  default: op = 4'h8;
      endcase
      if (k < 7)      return {cnd, 2'b00, r[25], op, r[20:0]};
      else if (k < 9) return {cnd, 2'b01, r[25:0]};
      else            return {cnd, 3'b101, r[24:0]};
   endfunction

   task automatic random_cycle();
      idle();
      bus.in_valid = ($urandom_range(0, 3) != 0);
      bus.instruction_in = rand_instr();
      bus.pc_in = $urandom;
      status_register = 4'($urandom_range(0, 15));
      flush = ($urandom_range(0, 24) == 0);
      bus.out_ready = flush ? 1'b0 : ($urandom_range(0, 2) != 0);
      wb_en = ($urandom_range(0, 1) == 1);
      wb_addr = 4'($urandom_range(0, 15));
      wb_data = $urandom;
      ex_wb_en = ($urandom_range(0, 4) == 0);
      ex_dst = 4'($urandom_range(0, 15));
      mem_wb_en = ($urandom_range(0, 4) == 0);
      mem_dst = 4'($urandom_range(0, 15));
   endtask

   initial begin
      idle();
      rst_n = 1'b0;
      step();
      reset_zero_checks();
      step();
      rst_n = 1'b1;

      // write R3 = 0xAA, then ADD R1,R3,R3 (AL)
      idle(); wb_en = 1'b1; wb_addr = 4'd3; wb_data = 32'h0000_00AA; step();
      idle(); present(32'hE083_1003, 32'h0000_0100, 1'b1); step();
      idle(); bus.out_ready = 1'b1; step();

      // same-cycle write of R5 bypassed into the read
      idle(); present(32'hE085_0006, 32'h0000_0104, 1'b1);
      wb_en = 1'b1; wb_addr = 4'd5; wb_data = 32'h0000_1234; step();
      idle(); bus.out_ready = 1'b1; step();

      // EX writes R2 for three cycles, ADD R4,R2,R2 waits then goes
      idle(); present(32'hE082_4002, 32'h0000_0108, 1'b1);
      ex_wb_en = 1'b1; ex_dst = 4'd2;
      repeat (3) step();
      ex_wb_en = 1'b0; step();
      idle(); bus.out_ready = 1'b1; step();

      // EQ with Z clear: bundle flows with side effects stripped
      idle(); present(32'h0083_1003, 32'h0000_010C, 1'b1); status_register = 4'h0; step();
      idle(); bus.out_ready = 1'b1; step();

      // backpressure for four cycles, then consume and accept together
      idle(); present(32'hE1A0_2003, 32'h0000_0110, 1'b1); step();
      idle(); present(32'hE590_1004, 32'h0000_0114, 1'b0); repeat (4) step();
      bus.out_ready = 1'b1; step();
      idle(); bus.out_ready = 1'b1; step();

      // flush kills the held bundle and the presented instruction
      idle(); present(32'hE080_1002, 32'h0000_0118, 1'b1); step();
      idle(); present(32'hE081_2003, 32'h0000_011C, 1'b0); flush = 1'b1; step();
      idle(); bus.out_ready = 1'b1; step();
      step();

      repeat (1500) begin
         random_cycle();
         step();
      end

      // reset in the middle of traffic
      random_cycle();
      rst_n = 1'b0;
      #1;
      reset_zero_checks();
      step();
      rst_n = 1'b1;

      repeat (1500) begin
         random_cycle();
         step();
      end

      idle(); bus.out_ready = 1'b1;
      repeat (4) step();
      check("queue_drained", exp_q.size(), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
